mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one single-port synchronous memory between the instruction-fetch port and the load/store port of the RISC-V core. It is used for a unified-memory build of the processor, in place of separate instruction and data memories. It grants one access at a time with round-robin fairness and tracks the single outstanding read until its data returns. Reads have a fixed latency of MEM_LAT cycles.

## Interface
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from memory issue to valid m_rdata; must be ≥1

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, level, held until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data; zero when i_rvalid=0
- d_req  in  1  data request, level, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data; zero when d_rvalid=0
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after m_en with m_we=0

## Operation
- **States:** IDLE and WAIT. Register cnt holds the remaining read latency. Register owner records which port the outstanding read belongs to. Register prio marks the port favoured on a tie.
- **Free:** the arbiter is free when the state is IDLE, or when the state is WAIT and cnt==1.
- **Arbitration when free:**
  - Only one port requesting: that port wins.
  - Both ports requesting: the port selected by prio wins.
- **Grant cycle (combinational):**
  - Winner's gnt=1.
  - m_en=1.
  - m_addr and m_we taken from the winner; m_we=0 for fetch.
  - m_wdata=d_wdata. It is driven with d_wdata even on fetches.
- **After a grant:**
  - prio flips to the port that was not granted.
  - Read grant: next state is WAIT, cnt←MEM_LAT, owner←winner.
  - Write grant: next state is IDLE. No rvalid is generated.
- **In WAIT:**
  - cnt decrements by 1 each cycle.
  - When cnt==1, owner's rvalid=1 and its rdata=m_rdata.
  - In that same cycle, a new grant may issue. If none issues, the next state is IDLE.
- **Ungranted requesters:** stall, holding req and operands. gnt is never asserted without req.
- **No requests:** with neither port requesting, m_en=0, m_we=0, and m_addr/m_wdata are held at 0.

## Timing
- **Read:** grant at cycle T; owner's rvalid is a single-cycle pulse at T+MEM_LAT.
- **Back-to-back reads:** a new read can be granted every MEM_LAT cycles.
- **Write:** grant at T; the memory writes at the edge ending T. A new grant is possible at T+1.
- **Outstanding reads:** at most one at any time.
- **Reset values:** while reset=0, and on release, all outputs are 0, state=IDLE, cnt=0, prio=data.
- **Reset mid-WAIT:** the outstanding read is dropped. No rvalid is produced after reset release.
- **First cycle after release:** requests present are arbitrated normally.
- **Same-port re-request:** the port receiving rvalid may request again in the same cycle and is granted if it wins arbitration.

## Structure
- **Package mem_arb_pkg:**
  - arb_state_t enum {IDLE, WAIT}
  - port_t enum {PORT_I, PORT_D}
  - Default width constants.
- **Sub-module rr_arb2:** combinational 2-way round-robin pick.
  - Inputs: req[1:0], prio.
  - Output: one-hot gnt[1:0].
  - mem_arbiter owns the FSM, cnt, owner and prio registers.

## Test plan
- **Lone fetch:** MEM_LAT=1, i_req=1 with i_addr=0x10 at T, memory returning 0xDEADBEEF.
  - i_gnt at T, m_en=1, m_addr=0x10.
  - i_rvalid=1 with i_rdata=0xDEADBEEF at T+1. d_rvalid stays 0.
- **Contention:** i_req and d_req both held high from reset release.
  - Grants alternate D, I, D, I.
  - Each read's rvalid lands on the correct port, MEM_LAT cycles after its grant.
- **Store then load:** d_we=1, d_addr=0x40, d_wdata=0x1234, followed by a load from 0x40.
  - The store is granted with m_we=1 and produces no rvalid.
  - The load is granted the next cycle and returns d_rdata=0x1234.
- **Longer latency:** MEM_LAT=3, fetch granted at T.
  - No grant during T+1..T+2, even with d_req=1.
  - i_rvalid at T+3, with d_gnt in the same cycle.
- **Reset mid-read:** MEM_LAT=3, reset asserted at T+1 after a read grant, released at T+2.
  - No rvalid occurs afterwards.
  - All outputs are 0 during reset.
  - The first post-release contention grants data.
- **Idle:** no requests for 10 cycles.
  - m_en=0 and no gnt or rvalid pulses.
  - The rdata outputs stay 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    // Port values double as bit indices into the request/grant vectors.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned MEM_LAT_DEF = 1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port named by prio.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default first so every path assigns gnt; no latch is inferred.
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (prio == PORT_D) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between fetch and load/store ports,
// granting one access at a time and tracking the single outstanding read.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int unsigned      CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    port_t            owner_q, owner_d;
    port_t            prio_q, prio_d;

    logic       rd_done;
    logic       free;
    logic [1:0] arb_req;
    logic [1:0] gnt_vec;

    // Everything combinational is qualified by reset so all outputs read 0 while it is held low.
    assign rd_done = reset && (state_q == WAIT) && (cnt_q == CNT_ONE);
    assign free    = reset && ((state_q == IDLE) || rd_done);
    assign arb_req = {2{free}} & {d_req, i_req};

    rr_arb2 u_rr_arb2 (
        .req  (arb_req),
        .prio (prio_q),
        .gnt  (gnt_vec)
    );

    assign i_gnt    = gnt_vec[PORT_I];
    assign d_gnt    = gnt_vec[PORT_D];
    assign m_en     = |gnt_vec;
    assign m_we     = gnt_vec[PORT_D] & d_we;
    assign m_addr   = gnt_vec[PORT_D] ? d_addr : (gnt_vec[PORT_I] ? i_addr : '0);
    assign m_wdata  = m_en ? d_wdata : '0;

    assign i_rvalid = rd_done && (owner_q == PORT_I);
    assign d_rvalid = rd_done && (owner_q == PORT_D);
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        prio_d  = prio_q;

        if (state_q == WAIT) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
            end
        end

        // A grant in the last WAIT cycle overrides the return to IDLE.
        if (m_en) begin
            prio_d = gnt_vec[PORT_I] ? PORT_D : PORT_I;
            if (m_we) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = WAIT;
                cnt_d   = LAT_INIT;
                owner_d = gnt_vec[PORT_I] ? PORT_I : PORT_D;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= PORT_I;
            prio_q  <= PORT_D;
        end else begin
            // NOTE: non-blocking for all state so every register updates together at the edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3, with a scoreboard of expected reads.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        port_t       port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;

    logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_m_en, a_m_we;
    logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_m_en, b_m_we;
    logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   sel   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_a (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(a_m_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_b (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata)
    );

    wire [5:0]  a_ctl = {a_m_en, a_m_we, a_i_gnt, a_d_gnt, a_i_rvalid, a_d_rvalid};
    wire [63:0] a_dat = {a_i_rdata, a_d_rdata};
    wire [63:0] a_bus = {a_m_addr, a_m_wdata};
    wire [5:0]  b_ctl = {b_m_en, b_m_we, b_i_gnt, b_d_gnt, b_i_rvalid, b_d_rvalid};
    wire [63:0] b_dat = {b_i_rdata, b_d_rdata};
    wire [63:0] b_bus = {b_m_addr, b_m_wdata};

    // Power-on memory contents; word 4 (byte 0x10) holds the fetch pattern.
    function automatic logic [31:0] init_val(int idx);
        return (idx == 4) ? 32'hDEADBEEF : (32'hA5A50000 + 32'(idx));
    endfunction

    // Memory models: written words tracked by flag, reads return a poison word when no read was issued.
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [63:0] wr_a = '0;
    logic [63:0] wr_b = '0;
    logic [31:0] a_rd, b_p0, b_p1, b_p2;

    assign a_m_rdata = a_rd;
    assign b_m_rdata = b_p2;

    always @(posedge clk) begin
        a_rd <= 32'hBAD0BAD0;
        if (a_m_en && a_m_we) begin
            mem_a[a_m_addr[7:2]] <= a_m_wdata;
            wr_a[a_m_addr[7:2]]  <= 1'b1;
        end else if (a_m_en) begin
            a_rd <= wr_a[a_m_addr[7:2]] ? mem_a[a_m_addr[7:2]] : init_val(int'(a_m_addr[7:2]));
        end
    end

    always @(posedge clk) begin
        b_p0 <= 32'hBAD0BAD0;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
        if (b_m_en && b_m_we) begin
            mem_b[b_m_addr[7:2]] <= b_m_wdata;
            wr_b[b_m_addr[7:2]]  <= 1'b1;
        end else if (b_m_en) begin
            b_p0 <= wr_b[b_m_addr[7:2]] ? mem_b[b_m_addr[7:2]] : init_val(int'(b_m_addr[7:2]));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic quiet(input string tag, input logic [5:0] ctl, input logic [63:0] dat,
                         input logic [63:0] bus);
        check({tag, "_ctl"}, {58'b0, ctl}, 64'd0);
        check({tag, "_rdata"}, dat, 64'd0);
        check({tag, "_bus"}, bus, 64'd0);
    endtask

    task automatic push(input port_t p, input logic [31:0] d, input int lat);
        exp_t e;
        e.port = p;
        e.data = d;
        e.cyc  = cyc + lat;
        q.push_back(e);
    endtask

    task automatic watch(input logic iv, input logic dv, input logic [31:0] ir, input logic [31:0] dr);
        exp_t e;
        if (!iv && !dv) return;
        check("rvalid_onehot", {63'b0, iv & dv}, 64'd0);
        if (q.size() == 0) begin
            check("rvalid_unexpected", {62'b0, iv, dv}, 64'd0);
            return;
        end
        e = q.pop_front();
        check("rvalid_port", {63'b0, dv}, {63'b0, (e.port == PORT_D)});
        check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
        check("rvalid_data", {32'b0, (dv ? dr : ir)}, {32'b0, e.data});
    endtask

    // Scoreboard side: every rvalid of the instance under test pops one expectation.
    always @(negedge clk) begin
        #1;
        if (sel == 0) watch(a_i_rvalid, a_d_rvalid, a_i_rdata, a_d_rdata);
        else          watch(b_i_rvalid, b_d_rvalid, b_i_rdata, b_d_rdata);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;

        // Reset with both requests high: every output stays 0.
        tick;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h30; d_wdata = 32'h55;
        settle;
        quiet("rst_a", a_ctl, a_dat, a_bus);
        quiet("rst_b", b_ctl, b_dat, b_bus);
        tick;
        i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0;
        reset = 1'b1;
        settle;
        quiet("rel_a", a_ctl, a_dat, a_bus);

        // Lone fetch, MEM_LAT=1.
        tick;
        i_req = 1'b1; i_addr = 32'h10; d_wdata = 32'h77;
        settle;
        check("fetch_ignt", a_i_gnt, 1);
        check("fetch_dgnt", a_d_gnt, 0);
        check("fetch_men", a_m_en, 1);
        check("fetch_mwe", a_m_we, 0);
        check("fetch_maddr", a_m_addr, 32'h10);
        check("fetch_mwdata", a_m_wdata, 32'h77);
        push(PORT_I, 32'hDEADBEEF, 1);
        tick;
        i_req = 1'b0; d_wdata = '0;
        settle;
        check("fetch_irvalid", a_i_rvalid, 1);
        check("fetch_irdata", a_i_rdata, 32'hDEADBEEF);
        check("fetch_drvalid", a_d_rvalid, 0);

        // Contention from reset release: D, I, D, I.
        tick;
        reset = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h20; d_addr = 32'h30; d_we = 1'b0;
        tick;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle;
            if (k % 2 == 0) begin
                check("cont_dgnt", {a_d_gnt, a_i_gnt}, 2'b10);
                check("cont_daddr", a_m_addr, 32'h30);
                push(PORT_D, init_val(12), 1);
            end else begin
                check("cont_ignt", {a_d_gnt, a_i_gnt}, 2'b01);
                check("cont_iaddr", a_m_addr, 32'h20);
                push(PORT_I, init_val(8), 1);
            end
            tick;
        end
        i_req = 1'b0; d_req = 1'b0;
        settle;
        check("cont_stop", {a_d_gnt, a_i_gnt}, 2'b00);
        tick;
        settle;
        check("cont_drained", 64'(q.size()), 0);

        // Store then load at 0x40.
        tick;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        settle;
        check("st_gnt", a_d_gnt, 1);
        check("st_mwe", a_m_we, 1);
        check("st_maddr", a_m_addr, 32'h40);
        check("st_mwdata", a_m_wdata, 32'h1234);
        tick;
        d_we = 1'b0;
        settle;
        check("ld_gnt", a_d_gnt, 1);
        check("ld_mwe", a_m_we, 0);
        push(PORT_D, 32'h1234, 1);
        tick;
        d_req = 1'b0;
        settle;
        check("ld_drvalid", a_d_rvalid, 1);
        check("ld_drdata", a_d_rdata, 32'h1234);

        // Idle for 10 cycles; d_wdata deliberately left non-zero.
        for (int k = 0; k < 10; k++) begin
            tick;
            settle;
            quiet("idle", a_ctl, a_dat, a_bus);
        end
        check("idle_drained", 64'(q.size()), 0);

        // Switch to the MEM_LAT=3 instance under reset.
        tick;
        reset = 1'b0; sel = 1;
        tick;
        reset = 1'b1; i_req = 1'b1; i_addr = 32'h10;
        settle;
        check("lat_ignt", b_i_gnt, 1);
        push(PORT_I, 32'hDEADBEEF, 3);
        tick;
        i_req = 1'b0; d_req = 1'b1; d_addr = 32'h30; d_we = 1'b0;
        settle;
        check("lat_stall1", {b_d_gnt, b_m_en}, 2'b00);
        tick;
        settle;
        check("lat_stall2", {b_d_gnt, b_m_en}, 2'b00);
        tick;
        settle;
        check("lat_irvalid", b_i_rvalid, 1);
        check("lat_irdata", b_i_rdata, 32'hDEADBEEF);
        check("lat_dgnt", b_d_gnt, 1);
        push(PORT_D, init_val(12), 3);
        tick;
        d_req = 1'b0;
        repeat (3) begin
            settle;
            tick;
        end
        settle;
        check("lat_drained", 64'(q.size()), 0);

        // Reset one cycle after a data read grant; the read must vanish.
        tick;
        d_req = 1'b1; d_addr = 32'h30; d_we = 1'b0;
        settle;
        check("rmr_gnt", b_d_gnt, 1);
        tick;
        reset = 1'b0; i_req = 1'b1; i_addr = 32'h20;
        settle;
        quiet("rmr_rst", b_ctl, b_dat, b_bus);
        tick;
        reset = 1'b1;
        settle;
        check("rmr_first", {b_d_gnt, b_i_gnt}, 2'b10);
        push(PORT_D, init_val(12), 3);
        tick;
        d_req = 1'b0; i_req = 1'b0;
        repeat (4) begin
            settle;
            tick;
        end
        settle;
        check("rmr_drained", 64'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
